dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/cpu_defs.sv | 32 +++
 rtl/resp_fifo.sv | 88 ++++++++
 rtl/dmem_responder.sv | 60 ++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared data-bus definitions: transfer size encodings, byte-strobe and alignment helpers.
package cpu_defs;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      SIZE_B:  s = 4'b0001 << off;
      SIZE_H:  s = off[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    m = 1'b1;
    case (size)
      SIZE_B:  m = 1'b0;
      SIZE_H:  m = off[0];
      SIZE_W:  m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order outstanding-response queue; each entry ages until it reaches LATENCY, then pops.
module resp_fifo #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  output logic        ready_o,
  output logic        pop_o,
  output logic [31:0] head_data_o
);

  localparam int unsigned Slots   = 4;
  localparam logic [2:0]  Lat     = 3'(LATENCY);
  localparam logic [2:0]  Depth   = 3'(DEPTH);
  localparam logic [1:0]  LastPtr = 2'(DEPTH - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q [Slots];
  logic [31:0] data_d [Slots];
  logic [2:0]  age_q  [Slots];
  logic [2:0]  age_d  [Slots];
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic        accept;

  always_comb begin
    pop_o       = (count_q != 3'd0) && (age_q[head_q] == Lat);
    ready_o     = (count_q < Depth) || pop_o;
    accept      = push_i && ready_o;
    head_data_o = pop_o ? data_q[head_q] : 32'h0;

    data_d  = data_q;
    age_d   = age_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;

    for (int i = 0; i < Slots; i++) begin
      if (age_q[i] < Lat) age_d[i] = age_q[i] + 3'd1;
    end
    // The accepting edge itself counts as the first cycle of age.
    if (accept) begin
      data_d[tail_q] = push_data_i;
      age_d[tail_q]  = 3'd1;
      tail_d         = (tail_q == LastPtr) ? 2'd0 : tail_q + 2'd1;
    end
    if (pop_o) head_d = (head_q == LastPtr) ? 2'd0 : head_q + 2'd1;

    case ({accept, pop_o})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (pop_o && !accept && count_q == 3'd1) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      for (int i = 0; i < Slots; i++) begin
        data_q[i] <= 32'h0;
        age_q[i]  <= 3'd0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      data_q  <= data_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: strobed word storage with fixed-latency, in-order responses.
module dmem_responder
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int unsigned Words = 2 ** ADDR_W;

  logic [31:0]       mem_q [Words];
  logic [ADDR_W-1:0] idx;
  logic [3:0]        strb;
  logic              mis;
  logic              wr_en;
  logic [31:0]       push_data;
  logic              unused_addr;

  // Upper address bits are ignored so the storage aliases.
  assign idx         = data_addr[ADDR_W+1:2];
  assign unused_addr = ^data_addr[31:ADDR_W+2];
  assign mis         = misaligned(data_size, data_addr[1:0]);
  assign strb        = strobe(data_size, data_addr[1:0]);
  assign wr_en       = data_req && data_addr_ok && data_wr && !mis && !rst;
  assign push_data   = (data_wr || mis) ? 32'h0 : mem_q[idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem_q[idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  resp_fifo #(
    .LATENCY(LATENCY),
    .DEPTH  (DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (data_req),
    .push_data_i(push_data),
    .ready_o    (data_addr_ok),
    .pop_o      (data_data_ok),
    .head_data_o(data_rdata)
  );

endmodule
